// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan multiplexer.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_DASH = 7'h40;
  localparam seg7_t SEG_OFF  = 7'h00;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to seven-segment decoder, segments {g,f,e,d,c,b,a}.
// Non-decimal codes show a dash so corrupted digits are visible.
import seg_pkg::*;

module bcd_to_seg7 (
  input  logic [3:0] bcd,
  output seg7_t      seg
);

  // Digit pattern lookup
  always_comb begin
    case (bcd)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Six-digit seven-segment scanner with per-frame snapshot, dead time and blink.
// Optional leading-zero suppression via macro SEG_LEADING_ZERO_BLANK_EN.
import seg_pkg::*;

module seg_scan_mux #(
  parameter int NUM_DIGITS  = 6,
  parameter int DIGIT_TICKS = 4,
  parameter int BLANK_TICKS = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic                    tick_in,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    blink_phase,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output seg7_t                   seg_out,
  output logic                    dp_out,
  output logic                    frame_start
);

  localparam int CNT_MAX = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_TICKS - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam scan_state_t      FIRST_STATE = (BLANK_TICKS > 0) ? BLANK : SHOW;

`ifdef SEG_LEADING_ZERO_BLANK_EN
  // Flags the run of zero digits from the top down; a dp or non-zero digit ends it.
  function automatic logic [NUM_DIGITS-1:0] lz_flags(
    input logic [4*NUM_DIGITS-1:0] bcd,
    input logic [NUM_DIGITS-1:0]   dp
  );
    logic run;
    lz_flags = '0;
    run      = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (run && (bcd[4*i +: 4] == 4'd0) && !dp[i]) begin
        lz_flags[i] = 1'b1;
      end else begin
        run = 1'b0;
      end
    end
  endfunction
`endif

  scan_state_t             state_r, nxt_state;
  logic                    tick_q_r;
  logic [IDX_W-1:0]        digit_idx_r, nxt_idx;
  logic [CNT_W-1:0]        tick_cnt_r, nxt_cnt;
  logic [4*NUM_DIGITS-1:0] snap_bcd_r, nxt_bcd;
  logic [NUM_DIGITS-1:0]   snap_dp_r, nxt_dp;
  logic [NUM_DIGITS-1:0]   blank_r, nxt_blank, lz_s;
  logic                    latch_s, tick_rise_s;
  logic [3:0]              cur_bcd_s;
  logic                    cur_dp_s, cur_blink_s, cur_lz_s;
  logic [NUM_DIGITS-1:0]   onehot_s, nxt_en;
  seg7_t                   dec_seg_s, nxt_seg;
  logic                    nxt_dpo;

  assign tick_rise_s = tick_in & ~tick_q_r;

`ifdef SEG_LEADING_ZERO_BLANK_EN
  assign lz_s = lz_flags(bcd_in, dp_in);
`else
  assign lz_s = '0;
`endif

  // Scan sequencing: ena dominates, otherwise advance only on tick rises
  always_comb begin
    nxt_state = state_r;
    nxt_idx   = digit_idx_r;
    nxt_cnt   = tick_cnt_r;
    latch_s   = 1'b0;
    if (!ena) begin
      nxt_state = IDLE;
      nxt_idx   = '0;
      nxt_cnt   = '0;
    end else if (tick_rise_s) begin
      case (state_r)
        IDLE: begin
          latch_s   = 1'b1;
          nxt_idx   = '0;
          nxt_cnt   = '0;
          nxt_state = FIRST_STATE;
        end
        BLANK: begin
          if (tick_cnt_r == BLANK_LAST) begin
            nxt_state = SHOW;
            nxt_cnt   = '0;
          end else begin
            nxt_cnt = tick_cnt_r + 1'b1;
          end
        end
        SHOW: begin
          if (tick_cnt_r == DIGIT_LAST) begin
            nxt_cnt   = '0;
            nxt_state = FIRST_STATE;
            if (digit_idx_r == IDX_LAST) begin
              nxt_idx = '0;
              latch_s = 1'b1;
            end else begin
              nxt_idx = digit_idx_r + 1'b1;
            end
          end else begin
            nxt_cnt = tick_cnt_r + 1'b1;
          end
        end
        default: begin
          nxt_state = IDLE;
          nxt_idx   = '0;
          nxt_cnt   = '0;
        end
      endcase
    end else begin
      nxt_state = state_r;
    end
  end

  assign nxt_bcd   = latch_s ? bcd_in : snap_bcd_r;
  assign nxt_dp    = latch_s ? dp_in  : snap_dp_r;
  assign nxt_blank = latch_s ? lz_s   : blank_r;

  // Select the digit that will be on the bus after this edge
  always_comb begin
    cur_bcd_s   = 4'd0;
    cur_dp_s    = 1'b0;
    cur_blink_s = 1'b0;
    cur_lz_s    = 1'b0;
    onehot_s    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (nxt_idx == IDX_W'(i)) begin
        cur_bcd_s   = nxt_bcd[4*i +: 4];
        cur_dp_s    = nxt_dp[i];
        cur_blink_s = blink_mask[i];
        cur_lz_s    = nxt_blank[i];
        onehot_s[i] = 1'b1;
      end else begin
        onehot_s[i] = 1'b0;
      end
    end
  end

  bcd_to_seg7 u_dec (
    .bcd (cur_bcd_s),
    .seg (dec_seg_s)
  );

  // Output values derived from the next state; blink_phase is applied live
  always_comb begin
    nxt_en  = '0;
    nxt_seg = SEG_OFF;
    nxt_dpo = 1'b0;
    if (nxt_state == SHOW) begin
      nxt_en = onehot_s;
      if (cur_blink_s && blink_phase) begin
        nxt_seg = SEG_OFF;
        nxt_dpo = 1'b0;
      end else begin
        nxt_seg = cur_lz_s ? SEG_OFF : dec_seg_s;
        nxt_dpo = cur_dp_s;
      end
    end else begin
      nxt_en = '0;
    end
  end

  // State, snapshot and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      tick_q_r    <= 1'b0;
      digit_idx_r <= '0;
      tick_cnt_r  <= '0;
      snap_bcd_r  <= '0;
      snap_dp_r   <= '0;
      blank_r     <= '0;
      digit_en    <= '0;
      seg_out     <= SEG_OFF;
      dp_out      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state_r     <= nxt_state;
      tick_q_r    <= tick_in;
      digit_idx_r <= nxt_idx;
      tick_cnt_r  <= nxt_cnt;
      snap_bcd_r  <= nxt_bcd;
      snap_dp_r   <= nxt_dp;
      blank_r     <= nxt_blank;
      digit_en    <= nxt_en;
      seg_out     <= nxt_seg;
      dp_out      <= nxt_dpo;
      frame_start <= latch_s;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux: table of whole-frame vectors plus
// hand sequences for mid-frame update, ena drop and async reset.
module tb_seg_scan_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        tick_in;
  logic [23:0] bcd_in;
  logic [5:0]  dp_in;
  logic [5:0]  blink_mask;
  logic        blink_phase;
  logic [5:0]  digit_en;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic        frame_start;

  int passed = 0;
  int total  = 0;
  int tcnt   = 0;

  seg_scan_mux #(.NUM_DIGITS(6), .DIGIT_TICKS(2), .BLANK_TICKS(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .tick_in     (tick_in),
    .bcd_in      (bcd_in),
    .dp_in       (dp_in),
    .blink_mask  (blink_mask),
    .blink_phase (blink_phase),
    .digit_en    (digit_en),
    .seg_out     (seg_out),
    .dp_out      (dp_out),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // Free-running scan tick: one clock high every 4 clocks
  initial begin
    tick_in = 1'b0;
    forever begin
      @(negedge clk);
      tcnt    = (tcnt + 1) % 4;
      tick_in = (tcnt == 0);
    end
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  typedef struct packed {
    logic [23:0] bcd;
    logic [5:0]  dp;
    logic [5:0]  mask;
    logic        phase;
    logic [41:0] segs;   // expected seg_out, digit 5 in the top 7 bits
    logic [5:0]  dpx;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [14:0] outs();
    return {digit_en, seg_out, dp_out, frame_start};
  endfunction

  task automatic chk(input string name, input logic [14:0] act, input logic [14:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h (en,seg,dp,fs)", name, act, exp);
  endtask

  task automatic wait_fs(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = frame_start;
    end
    if (!seen) begin
      total++;
      $display("FAIL %s: frame_start timeout got 0 want 1", name);
    end
  endtask

  // Called at the sample where frame_start is seen; checks 72 cycles and the wrap
  task automatic run_frame(input logic [41:0] segs, input logic [5:0] dpx, input string name);
    for (int n = 0; n < 72; n++) begin
      int d  = n / 12;
      int ph = n % 12;
      logic [5:0]  en;
      logic [14:0] exp;
      en = 6'd1 << d;
      if (ph < 4) exp = {6'd0, 7'd0, 1'b0, (n == 0)};
      else        exp = {en, segs[7*d +: 7], dpx[d], 1'b0};
      chk(name, outs(), exp);
      @(negedge clk);
    end
    chk({name, "_wrap"}, outs(), {6'd0, 7'd0, 1'b0, 1'b1});
  endtask

  initial begin
    vecs[0] = {24'h123456, 6'b000000, 6'b000000, 1'b0,
               {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D}, 6'b000000};
    vecs[1] = {24'h999999, 6'b000000, 6'b000000, 1'b0,
               {6{7'h6F}}, 6'b000000};
    vecs[2] = {24'h123456, 6'b000101, 6'b000011, 1'b1,
               {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h00, 7'h00}, 6'b000100};
    vecs[3] = {24'h000120, 6'b000000, 6'b000000, 1'b0,
               LZ ? {7'h00, 7'h00, 7'h00, 7'h06, 7'h5B, 7'h3F}
                  : {7'h3F, 7'h3F, 7'h3F, 7'h06, 7'h5B, 7'h3F}, 6'b000000};
    vecs[4] = {24'h0000AF, 6'b000000, 6'b000000, 1'b0,
               LZ ? {7'h00, 7'h00, 7'h00, 7'h00, 7'h40, 7'h40}
                  : {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h40, 7'h40}, 6'b000000};
    vecs[5] = {24'h000000, 6'b010000, 6'b000000, 1'b0,
               LZ ? {7'h00, {5{7'h3F}}} : {6{7'h3F}}, 6'b010000};
    vecs[6] = {24'h000000, 6'b000000, 6'b000000, 1'b0,
               LZ ? {{5{7'h00}}, 7'h3F} : {6{7'h3F}}, 6'b000000};
    vecs[7] = {24'h876543, 6'b000000, 6'b111111, 1'b0,
               {7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F}, 6'b000000};

    rst = 1'b0; ena = 1'b0; bcd_in = 24'h0; dp_in = 6'h0;
    blink_mask = 6'h0; blink_phase = 1'b0;
    repeat (5) @(negedge clk);
    chk("in_reset", outs(), 15'd0);
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("idle_ena0", outs(), 15'd0);
    end

    ena = 1'b1;
    for (int v = 0; v < 8; v++) begin
      bcd_in = vecs[v].bcd; dp_in = vecs[v].dp;
      blink_mask = vecs[v].mask; blink_phase = vecs[v].phase;
      wait_fs($sformatf("vec%0d_start", v));
      run_frame(vecs[v].segs, vecs[v].dpx, $sformatf("vec%0d", v));
    end

    // Mid-frame bcd change must not tear the current frame
    bcd_in = 24'h123456; dp_in = 6'h0; blink_mask = 6'h0; blink_phase = 1'b0;
    wait_fs("tear_start");
    repeat (20) @(negedge clk);
    bcd_in = 24'h999999;
    repeat (20) @(negedge clk);
    chk("tear_d3", outs(), {6'b001000, 7'h4F, 1'b0, 1'b0});
    repeat (24) @(negedge clk);
    chk("tear_d5", outs(), {6'b100000, 7'h06, 1'b0, 1'b0});
    wait_fs("tear_next");
    run_frame({6{7'h6F}}, 6'b000000, "tear_next");

    // ena dropped on the same edge as a tick during SHOW of digit 0
    bcd_in = 24'h123456;
    wait_fs("ena_start");
    repeat (7) @(negedge clk);
    chk("ena_pre", outs(), {6'b000001, 7'h7D, 1'b0, 1'b0});
    ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("ena_drop", outs(), 15'd0);
    end
    ena = 1'b1;
    wait_fs("ena_restart");
    run_frame(vecs[0].segs, 6'b000000, "ena_restart");

    // Async reset mid-frame clears outputs without a clock edge
    wait_fs("rst_start");
    repeat (45) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_async", outs(), 15'd0);
    @(negedge clk);
    rst = 1'b1;
    wait_fs("rst_restart");
    run_frame(vecs[0].segs, 6'b000000, "rst_restart");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Six-digit seven-segment display scanner for the timer/stopwatch; sits directly downstream of pwm_generator.
- Consumes a pwm_generator pulse train as its scan tick and a second, slow pwm_generator output as its blink phase.
- Each frame, latches the BCD value for all six digits. Then it time-multiplexes one digit at a time onto the shared segment bus, inserting anti-ghosting dead time between digits.

Parameters:
- NUM_DIGITS, 6: number of digits scanned; digit 0 is the least significant (rightmost).
- DIGIT_TICKS, 4: scan ticks each digit is shown; must be ≥1.
- BLANK_TICKS, 1: dead-time ticks before each digit with all outputs off; 0 disables dead time.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- ena  in  1  scan enable.
- tick_in  in  1  scan tick from pwm_generator; rising edge detected internally, so any pulse width is accepted.
- bcd_in  in  4*NUM_DIGITS  digit i in bits [4i+3:4i].
- dp_in  in  NUM_DIGITS  decimal point per digit.
- blink_mask  in  NUM_DIGITS  digits subject to blinking.
- blink_phase  in  1  from a slow pwm_generator; 1 = blink-off phase.
- digit_en  out  NUM_DIGITS  one-hot, active-high digit drive.
- seg_out  out  7  segments {g,f,e,d,c,b,a}, active-high.
- dp_out  out  1  decimal point, active-high.
- frame_start  out  1  one-cycle pulse when a new frame snapshot is latched.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; tick_q=0; digit_idx=0; tick_cnt=0; snapshot=0.
  - digit_en=0, seg_out=0, dp_out=0, frame_start=0.
- Tick detection:
  - tick_q <= tick_in every edge.
  - tick_rise = tick_in & ~tick_q.
  - The state advances on the first edge at which tick_in is sampled high; no further latency.
- Outputs are registered from next-state, so they change on the same edge as the state.
- States: IDLE, BLANK, SHOW.
- IDLE:
  - All outputs 0.
  - On ena=1 & tick_rise: digit_idx=0, latch snapshot of bcd_in/dp_in, pulse frame_start.
  - Go to BLANK if BLANK_TICKS>0, else SHOW.
- BLANK:
  - digit_en=0, seg_out=0, dp_out=0.
  - Stays BLANK_TICKS tick_rises, then goes to SHOW with tick_cnt cleared.
- SHOW:
  - digit_en = 1<<digit_idx.
  - seg_out = decode(snapshot digit), dp_out = snapshot dp.
  - After DIGIT_TICKS tick_rises: digit_idx increments and the block enters BLANK/SHOW for the next digit.
  - Wrap: NUM_DIGITS-1 → 0. On wrap, re-latch the snapshot and pulse frame_start; same edge, no idle gap.
- Blink:
  - In SHOW, if blink_mask[digit_idx] & blink_phase, then seg_out=0 and dp_out=0; digit_en stays asserted.
  - blink_phase is applied live, not latched.
- Decode:
  - 0-9 → standard patterns (0=7'h3F … 9=7'h6F, 1=7'h06, 8=7'h7F).
  - 10-15 → 7'h40 (dash).
- bcd_in changes mid-frame are ignored until the next wrap, so there is no tearing.
- ena=0: synchronous return to IDLE on the next edge, all outputs 0, counters cleared, regardless of tick_rise.
- tick_rise coincident with ena falling: ena wins.
- Counters are sized $clog2 of their max+1, minimum 1 bit.

Optional Feature:
- Macro: SEG_LEADING_ZERO_BLANK_EN.
- Defined: at latch time, every contiguous zero digit from NUM_DIGITS-1 downward is flagged blank, stopping at the first non-zero digit.
  - Digit 0 is never blanked.
  - A digit with dp set ends the blank run.
  - Flagged digits output seg_out=0; digit_en timing is unchanged.
- Undefined: all digits are always shown.

Decomposition:
- Package seg_pkg:
  - scan_state_t enum {IDLE, BLANK, SHOW}.
  - seg7_t (logic [6:0]).
  - Constants SEG_DASH=7'h40, SEG_OFF=7'h00.
- Sub-module bcd_to_seg7: purely combinational, 4-bit in, seg7_t out.

Test Plan (NUM_DIGITS=6, DIGIT_TICKS=2, BLANK_TICKS=1, tick_in from pwm_generator PRESCALER=3, PULSE_WIDTH=1, i.e. one tick per 4 clk):
- Reset held, then rst=1 with ena=0 → all outputs 0 indefinitely, no frame_start.
- ena=1, bcd_in=24'h123456 → frame_start once.
  - Then sequence: 1 tick blank, 2 ticks digit_en=6'b000001 with seg_out=7'h7D ('6').
  - Then 1 tick blank, 2 ticks digit_en=6'b000010 with seg_out=7'h6D ('5').
  - Continue through digit_en=6'b100000 with seg_out=7'h06 ('1'), then frame_start again; frame period 72 clk.
- bcd_in changed to 24'h999999 mid-frame → current frame still shows 123456; next frame shows seg_out=7'h6F on all digits.
- blink_mask=6'b000011, blink_phase=1 → digits 0-1 have digit_en pulses but seg_out=0; others unaffected.
- With SEG_LEADING_ZERO_BLANK_EN: bcd_in=24'h000120 → digits 5,4,3 seg_out=0; digit 0 shows 7'h3F.
  - Without the macro, digits 5,4,3 show 7'h3F.
- ena dropped mid-SHOW, then rst pulsed low mid-frame → outputs 0 at the next edge (ena) or immediately (rst).
  - Restart begins at digit 0 with frame_start.
